ln_mean_accumulator: RTL and testbench
======================================

// Module: ln_mean_accumulator
// PURPOSE
// - Downstream consumer of the combinational float32 ln unit: collects a stream of ln results and
//   produces the mean negative log-likelihood  out = -(sum of samples) / (sample count).
// - Registers each ln result on entry, which breaks the long ln combinational path. Accumulates with
//   the shared float32 sum unit, converts the count with an internal int-to-float encoder, and
//   finishes with the shared divide unit. Feeds the loss/statistics path of the TPU.
// PARAMETERS
// - COUNT_WIDTH  16  width of the unsigned sample counter; the count saturates at 2**COUNT_WIDTH-1
// PORTS
// - clk        in   1   single clock, rising edge
// - rst        in   1   asynchronous, active-high reset
// - in_valid   in   1   inputA carries an ln result
// - in_ready   out  1   block accepts a sample this cycle
// - in_last    in   1   final sample of the current batch (qualified by in_valid && in_ready)
// - inputA     in   32  IEEE-754 single ln(x) value
// - out_valid  out  1   out holds the batch result
// - out_ready  in   1   downstream consumes out
// - out        out  32  IEEE-754 single, -(sum)/count
// - count      out  COUNT_WIDTH  samples accumulated in the current or last batch
// - overflow   out  1   sticky per batch; set when the counter saturated
// BEHAVIOUR
// - Reset (async, rst=1): state=IDLE; acc=+0.0; sample_q=+0.0; sample_vq=0; count=0; overflow=0;
//   out=0x00000000; out_valid=0; in_ready=0 while rst is high. Reset mid-batch discards all data.
// - accept = in_valid && in_ready. in_ready=1 in IDLE and ACCUM only, with no combinational path
//   from in_valid to in_ready.
// - Input stage: on accept, sample_q<=inputA and sample_vq<=1; otherwise sample_vq<=0.
// - Accumulate: on every edge with sample_vq=1, acc<=sum(acc,sample_q) and count<=count+1.
//   If count==2**COUNT_WIDTH-1, count holds and overflow<=1.
// - Accumulation is fully pipelined: one sample per cycle sustained, and gaps in in_valid are allowed.
// - FSM:
//   - IDLE: on accept, clear acc=+0.0, count=0 and overflow=0, then go to ACCUM.
//     If that first sample also has in_last, go straight to FLUSH.
//   - ACCUM: on accept with in_last go to FLUSH; otherwise stay.
//   - FLUSH (in_ready=0): add the last sample_q, then go to CONVERT.
//   - CONVERT: cnt_f<=int_to_float(count). The conversion is exact up to 24 bits; beyond that,
//     truncate toward zero. Then go to DIVIDE.
//   - DIVIDE: out<=divide({~acc[31],acc[30:0]}, cnt_f); out_valid<=1; go to DONE.
//   - DONE: hold out, count and overflow. On out_valid && out_ready, set out_valid<=0 and go to IDLE.
//     in_ready stays 0 until the cycle after the handshake, so there is no input/output overlap.
// - Latency: with edge E0 accepting the in_last sample, out_valid=1 after edge E3
//   (3 cycles, independent of batch length).
// - out and count stay stable while out_valid=1 && out_ready=0.
// - Arithmetic:
//   - All float ops use the shared sum, divide and multiply units with their rounding.
//   - Negation is a sign-bit flip.
//   - NaN/Inf in any sample propagate per those units; no special casing.
//   - ln(1)=+0.0 samples add exactly.
// - in_last while not in_ready is ignored, because no accept occurs.
//   in_valid during FLUSH/CONVERT/DIVIDE/DONE is held off by in_ready=0.
// TESTING
// - Single sample 0xC0000000 (-2.0) with in_last -> out=0x40000000 (2.0), count=1, out_valid 3 cycles
//   after accept.
// - Four back-to-back samples 0xBF317218 (ln 0.5), last on the 4th -> out=0x3F317218 (+/-1 ulp),
//   count=4, in_ready=1 every ACCUM cycle.
// - Samples -1.0, -2.0, -3.0 with 2-cycle in_valid gaps, last on -3.0 -> out=0x40000000 (2.0),
//   count=3.
// - out_ready held low 5 cycles in DONE -> out_valid, out and count stable, in_ready=0; next batch
//   accepted only after the handshake.
// - COUNT_WIDTH=4: 20 samples of -1.0 -> count=15, overflow=1, out = 20/15 per the divide unit;
//   overflow clears on the next batch's first accept.
// - Assert rst asynchronously mid-ACCUM (between edges) -> all outputs at reset values immediately;
//   the next batch of -1.0,-1.0(last) -> out=0x3F800000.

Source files
------------

// File: rtl/ln_mean_accumulator.sv
// ln_mean_accumulator: mean negative log-likelihood of a stream of float32 ln results.
//   out = -(sum of samples) / (sample count), produced once per batch (in_last closes a batch).
// Ports:
//   clk, rst             clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready    input handshake; inputA is an IEEE-754 single ln value
//   in_last              final sample of the batch, qualified by the handshake
//   out_valid/out_ready  output handshake; out is IEEE-754 single -(sum)/count
//   count                samples in the current or last batch (saturating)
//   overflow             sticky per batch, set once the counter saturated
module ln_mean_accumulator #(
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
  input  logic [31:0]            inputA,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out,
  output logic [COUNT_WIDTH-1:0] count,
  output logic                   overflow
);

  typedef enum logic [2:0] {StIdle, StAccum, StFlush, StConvert, StDivide, StDone} state_e;

  localparam logic [COUNT_WIDTH-1:0] CountMax = '1;

  // Float32 add, round-to-nearest-even, subnormals supported.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [9:0]  ex, ey, dd, e;
    logic [26:0] mx, my;
    logic [27:0] s;
    logic [24:0] m;
    logic        rnd, sticky;
    if (a[30:23] == 8'hff || b[30:23] == 8'hff) begin
      if ((a[30:23] == 8'hff && a[22:0] != 23'd0) || (b[30:23] == 8'hff && b[22:0] != 23'd0) ||
          (a[30:23] == 8'hff && b[30:23] == 8'hff && a[31] != b[31]))
        return 32'h7fc00000;
      return (a[30:23] == 8'hff) ? a : b;
    end
    // Order by magnitude so the aligned subtraction never goes negative.
    if (a[30:0] >= b[30:0]) begin x = a; y = b; end
    else begin x = b; y = a; end
    ex = (x[30:23] == 8'd0) ? 10'd1 : {2'b00, x[30:23]};
    ey = (y[30:23] == 8'd0) ? 10'd1 : {2'b00, y[30:23]};
    mx = {x[30:23] != 8'd0, x[22:0], 3'b000};
    my = {y[30:23] != 8'd0, y[22:0], 3'b000};
    dd = ex - ey;
    if (dd > 10'd26) begin
      sticky = |my;
      my     = '0;
    end else begin
      sticky = |(my & ((27'd1 << dd) - 27'd1));
      my     = my >> dd;
    end
    my[0] = my[0] | sticky;
    if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, my};
    else                s = {1'b0, mx} - {1'b0, my};
    if (s == 28'd0) return {x[31] & y[31], 31'd0};
    e = ex;
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'd1;
    end else begin
      for (int i = 0; i < 26; i++) begin
        if (!s[26] && e > 10'd1) begin
          s = s << 1;
          e = e - 10'd1;
        end
      end
    end
    rnd = s[2] & (s[1] | s[0] | s[3]);
    m   = {1'b0, s[26:3]} + 25'(rnd);
    if (m[24]) begin
      m = m >> 1;
      e = e + 10'd1;
    end
    if (e >= 10'd255) return {x[31], 8'hff, 23'd0};
    // A result left without the hidden bit is subnormal: exponent field 0.
    return {x[31], m[23] ? e[7:0] : 8'h00, m[22:0]};
  endfunction

  // Float32 divide, round-to-nearest-even; underflow flushes to signed zero.
  function automatic logic [31:0] fp_div(input logic [31:0] a, input logic [31:0] b);
    logic        sgn, rnd;
    logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    int          ea, eb, e;
    logic [23:0] ma, mb, rem;
    logic [49:0] num, den;
    logic [26:0] q, qn;
    logic [24:0] m;
    sgn    = a[31] ^ b[31];
    a_nan  = (a[30:23] == 8'hff) && (a[22:0] != 23'd0);
    b_nan  = (b[30:23] == 8'hff) && (b[22:0] != 23'd0);
    a_inf  = (a[30:23] == 8'hff) && (a[22:0] == 23'd0);
    b_inf  = (b[30:23] == 8'hff) && (b[22:0] == 23'd0);
    a_zero = (a[30:0] == 31'd0);
    b_zero = (b[30:0] == 31'd0);
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) return 32'h7fc00000;
    if (a_inf || b_zero) return {sgn, 8'hff, 23'd0};
    if (a_zero || b_inf) return {sgn, 31'd0};
    ea = (a[30:23] == 8'd0) ? 1 : int'({24'd0, a[30:23]});
    eb = (b[30:23] == 8'd0) ? 1 : int'({24'd0, b[30:23]});
    ma = {a[30:23] != 8'd0, a[22:0]};
    mb = {b[30:23] != 8'd0, b[22:0]};
    for (int i = 0; i < 23; i++) begin
      if (!ma[23]) begin ma = ma << 1; ea = ea - 1; end
      if (!mb[23]) begin mb = mb << 1; eb = eb - 1; end
    end
    e   = ea - eb + 127;
    num = {ma, 26'd0};
    den = {26'd0, mb};
    q   = 27'(num / den);
    rem = 24'(num % den);
    if (q[26]) qn = q;
    else begin
      qn = {q[25:0], 1'b0};
      e  = e - 1;
    end
    rnd = qn[2] & (qn[1] | qn[0] | (rem != 24'd0) | qn[3]);
    m   = {1'b0, qn[26:3]} + 25'(rnd);
    if (m[24]) begin
      m = m >> 1;
      e = e + 1;
    end
    if (e >= 255) return {sgn, 8'hff, 23'd0};
    if (e <= 0)   return {sgn, 31'd0};
    return {sgn, 8'(e), m[22:0]};
  endfunction

  // Unsigned to float32; exact up to 24 significant bits, truncated beyond.
  function automatic logic [31:0] int_to_float(input logic [31:0] v);
    int          p;
    logic [31:0] mant;
    if (v == 32'd0) return 32'd0;
    p = 0;
    for (int i = 0; i < 32; i++) if (v[i]) p = i;
    if (p <= 23) mant = v << (23 - p);
    else         mant = v >> (p - 23);
    return {1'b0, 8'(127 + p), mant[22:0]};
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            acc_q, sample_q, cnt_f_q, out_q;
  logic                   sample_vq, out_valid_q, overflow_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   accept;

  // in_ready depends on state and rst only, never on in_valid.
  assign in_ready  = ~rst & (state_q == StIdle || state_q == StAccum);
  assign accept    = in_valid & in_ready;
  assign out_valid = out_valid_q;
  assign out       = out_q;
  assign count     = count_q;
  assign overflow  = overflow_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = in_last ? StFlush : StAccum;
      StAccum:   if (accept && in_last) state_d = StFlush;
      StFlush:   state_d = StConvert;
      StConvert: state_d = StDivide;
      StDivide:  state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      acc_q       <= 32'd0;
      sample_q    <= 32'd0;
      sample_vq   <= 1'b0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      cnt_f_q     <= 32'd0;
      out_q       <= 32'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sample_vq <= accept;
      if (accept) sample_q <= inputA;
      // sample_vq is never set in IDLE, so clearing and accumulating cannot collide.
      if (state_q == StIdle && accept) begin
        acc_q      <= 32'd0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else if (sample_vq) begin
        acc_q <= fp_add(acc_q, sample_q);
        if (count_q == CountMax) overflow_q <= 1'b1;
        else                     count_q    <= count_q + 1'b1;
      end
      if (state_q == StConvert) cnt_f_q <= int_to_float(32'(count_q));
      if (state_q == StDivide) begin
        out_q       <= fp_div({~acc_q[31], acc_q[30:0]}, cnt_f_q);
        out_valid_q <= 1'b1;
      end
      if (state_q == StDone && out_ready) out_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ln_mean_accumulator.sv
module tb_ln_mean_accumulator;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_last, out_ready;
  logic [31:0] inputA;
  logic        in_ready, out_valid, overflow;
  logic [31:0] out;
  logic [15:0] count;

  logic        in_valid4, in_last4, out_ready4;
  logic [31:0] inputA4;
  logic        in_ready4, out_valid4, overflow4;
  logic [31:0] out4;
  logic [3:0]  count4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ln_mean_accumulator #(.COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .inputA(inputA), .out_valid(out_valid), .out_ready(out_ready), .out(out), .count(count),
    .overflow(overflow)
  );

  ln_mean_accumulator #(.COUNT_WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_last(in_last4),
    .inputA(inputA4), .out_valid(out_valid4), .out_ready(out_ready4), .out(out4),
    .count(count4), .overflow(overflow4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid of the selected instance.
  task automatic wait_out(input string tag, input bit narrow, input int maxc);
    int n = 0;
    while (((narrow ? out_valid4 : out_valid) !== 1'b1) && n < maxc) begin
      step();
      n++;
    end
    chk(tag, {31'd0, narrow ? out_valid4 : out_valid}, 32'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hs_out_valid_low", {31'd0, out_valid}, 32'd0);
    chk("hs_in_ready_high", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; inputA = 32'd0; out_ready = 1'b0;
    in_valid4 = 1'b0; in_last4 = 1'b0; inputA4 = 32'd0; out_ready4 = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out", out, 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    #10 rst = 1'b0;
    step();
    chk("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Single -2.0 with in_last: exact 3-edge latency.
    in_valid = 1'b1; inputA = 32'hC0000000; in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    chk("t1_flush_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_e0_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_e1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_e2_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("t1_e3_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_out", out, 32'h40000000);
    chk("t1_count", 32'(count), 32'd1);
    chk("t1_overflow", {31'd0, overflow}, 32'd0);
    handshake();

    // Four back-to-back ln(0.5); sum is exact so the mean is exactly ln(0.5) negated.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; inputA = 32'hBF317218; in_last = (i == 3);
      chk("t2_in_ready", {31'd0, in_ready}, 32'd1);
      step();
    end
    in_valid = 1'b0; in_last = 1'b0;
    wait_out("t2_timeout", 1'b0, 8);
    chk("t2_out", out, 32'h3F317218);
    chk("t2_count", 32'(count), 32'd4);
    handshake();

    // -1, -2, -3 with two idle cycles between samples.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_last = (i == 2);
      inputA = (i == 0) ? 32'hBF800000 : (i == 1) ? 32'hC0000000 : 32'hC0400000;
      step();
      in_valid = 1'b0; in_last = 1'b0;
      if (i < 2) begin
        step();
        chk("t3_gap_in_ready", {31'd0, in_ready}, 32'd1);
        step();
      end
    end
    wait_out("t3_timeout", 1'b0, 8);
    chk("t3_out", out, 32'h40000000);
    chk("t3_count", 32'(count), 32'd3);

    // Backpressure in DONE while a new sample is offered.
    in_valid = 1'b1; inputA = 32'hBF800000; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t4_valid_held", {31'd0, out_valid}, 32'd1);
      chk("t4_out_held", out, 32'h40000000);
      chk("t4_count_held", 32'(count), 32'd3);
      chk("t4_in_ready_low", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("t4_hs_valid", {31'd0, out_valid}, 32'd0);
    chk("t4_count_kept", 32'(count), 32'd3);
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_out("t4_timeout", 1'b0, 8);
    chk("t4_out", out, 32'h3F800000);
    chk("t4_count", 32'(count), 32'd1);
    handshake();

    // Narrow counter: 20 x -1.0 saturates at 15; 20/15 rounds to 0x3FAAAAAB.
    for (int i = 0; i < 20; i++) begin
      in_valid4 = 1'b1; inputA4 = 32'hBF800000; in_last4 = (i == 19);
      step();
    end
    in_valid4 = 1'b0; in_last4 = 1'b0;
    wait_out("t5_timeout", 1'b1, 8);
    chk("t5_count", 32'(count4), 32'd15);
    chk("t5_overflow", {31'd0, overflow4}, 32'd1);
    chk("t5_out", out4, 32'h3FAAAAAB);
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;
    in_valid4 = 1'b1; inputA4 = 32'hBF800000; in_last4 = 1'b1;
    step();
    in_valid4 = 1'b0; in_last4 = 1'b0;
    chk("t5_overflow_clear", {31'd0, overflow4}, 32'd0);
    wait_out("t5b_timeout", 1'b1, 8);
    chk("t5b_out", out4, 32'h3F800000);
    chk("t5b_count", 32'(count4), 32'd1);
    out_ready4 = 1'b1;
    step();
    out_ready4 = 1'b0;

    // Asynchronous reset between edges in the middle of a batch.
    in_valid = 1'b1; inputA = 32'hBF800000; in_last = 1'b0;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("t6_pre_count", 32'(count), 32'd2);
    #3 rst = 1'b1;
    #1;
    chk("t6_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("t6_rst_count", 32'(count), 32'd0);
    chk("t6_rst_out", out, 32'd0);
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("t6_rst_overflow", {31'd0, overflow}, 32'd0);
    #2 rst = 1'b0;
    step();
    in_valid = 1'b1; inputA = 32'hBF800000; in_last = 1'b0;
    step();
    in_last = 1'b1;
    step();
    in_valid = 1'b0; in_last = 1'b0;
    wait_out("t6_timeout", 1'b0, 8);
    chk("t6_out", out, 32'h3F800000);
    chk("t6_count", 32'(count), 32'd2);
    handshake();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
